// File: rtl/product_accumulator_pkg.sv
// Shared types and default sizing for the product accumulator slice.
package product_accumulator_pkg;

    localparam int unsigned DEF_ACC_W = 12;
    localparam int unsigned DEF_BEATS = 4;
    localparam int unsigned P_W       = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Counter must hold the value BEATS itself once a frame completes.
    function automatic int unsigned cnt_width(input int unsigned beats);
        return (beats < 2) ? 1 : $clog2(beats + 1);
    endfunction

endpackage

// File: rtl/product_accumulator_beat_counter.sv
// Per-frame beat counter with load, increment, clear and terminal flag.
module beat_counter
    import product_accumulator_pkg::*;
#(
    parameter int unsigned BEATS = DEF_BEATS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic load,
    input  logic inc,
    output logic last_c
);

    localparam int unsigned CNT_W = cnt_width(BEATS);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(1);
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // True while the beat about to be accepted is the last of the frame.
    assign last_c = (cnt == CNT_W'(BEATS - 1));

endmodule

// File: rtl/product_accumulator.sv
// Frames BEATS unsigned products into one sum with overflow flag and a
// ready/valid result stage. Define SATURATE_EN to clamp instead of wrap.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int unsigned ACC_W = DEF_ACC_W,
    parameter int unsigned BEATS = DEF_BEATS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [P_W-1:0]   in_p,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    localparam int unsigned SUM_W = ACC_W + 1;

    state_t           state;
    state_t           state_n;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_n;
    logic             ovf;
    logic             ovf_n;
    logic [SUM_W-1:0] sum_c;
    logic [ACC_W-1:0] add_c;
    logic             cnt_clr;
    logic             cnt_load;
    logic             cnt_inc;
    logic             last_c;

    beat_counter #(
        .BEATS (BEATS)
    ) u_beat_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cnt_clr),
        .load   (cnt_load),
        .inc    (cnt_inc),
        .last_c (last_c)
    );

    assign sum_c = {1'b0, acc} + SUM_W'(in_p);

`ifdef SATURATE_EN
    // Once clamped at all-ones any nonzero product carries again, so it stays clamped.
    assign add_c = sum_c[ACC_W] ? {ACC_W{1'b1}} : sum_c[ACC_W-1:0];
`else
    assign add_c = sum_c[ACC_W-1:0];
`endif

    assign in_ready  = (state != HOLD) || out_ready;
    assign out_valid = (state == HOLD);
    assign out_sum   = acc;
    assign out_ovf   = ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            ovf   <= ovf_n;
        end
    end

    // Next-state, datapath and counter controls; clear overrides everything.
    always_comb begin
        state_n  = state;
        acc_n    = acc;
        ovf_n    = ovf;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;

        if (clear) begin
            state_n = IDLE;
            acc_n   = '0;
            ovf_n   = 1'b0;
            cnt_clr = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc_n    = ACC_W'(in_p);
                        ovf_n    = 1'b0;
                        cnt_load = 1'b1;
                        state_n  = (BEATS == 1) ? HOLD : ACC;
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        acc_n   = add_c;
                        ovf_n   = ovf | sum_c[ACC_W];
                        cnt_inc = 1'b1;
                        if (last_c) begin
                            state_n = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            acc_n    = ACC_W'(in_p);
                            ovf_n    = 1'b0;
                            cnt_load = 1'b1;
                            state_n  = (BEATS == 1) ? HOLD : ACC;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 The block SHALL have parameter ACC_W, default 12: accumulator and out_sum width in bits; minimum 8.
REQ-002 The block SHALL have parameter BEATS, default 4: number of products per frame; minimum 1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_p carries a valid product.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept in_p this cycle.
REQ-007 The block SHALL have port in_p, input, 8 bits: unsigned product from the upstream 4x4 multiplier.
REQ-008 The block SHALL have port clear, input, 1 bit: synchronous frame abort.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_sum and out_ovf hold a completed frame.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream stage accepts the result.
REQ-011 The block SHALL have port out_sum, output, ACC_W bits: the frame sum.
REQ-012 The block SHALL have port out_ovf, output, 1 bit: the frame sum exceeded 2^ACC_W-1.

Function
REQ-013 The FSM SHALL have states IDLE, ACC and HOLD; out_valid SHALL be 1 only in HOLD.
REQ-014 in_ready SHALL be 1 in IDLE and ACC, and in HOLD SHALL equal out_ready (combinational).
REQ-015 An input transfer SHALL occur on a rising edge with in_valid and in_ready both 1; in_valid gaps SHALL be allowed at any point.
REQ-016 On a transfer in IDLE: acc SHALL be loaded with zero-extended in_p, cnt set to 1, out_ovf cleared; next state ACC, or HOLD if BEATS==1.
REQ-017 On a transfer in ACC: acc SHALL become acc+in_p and cnt SHALL increment; when cnt==BEATS-1 before the edge, next state SHALL be HOLD.
REQ-018 Latency: out_valid SHALL assert on the first rising edge after the BEATS-th transfer.
REQ-019 In HOLD with out_ready=0, out_sum, out_ovf and out_valid SHALL remain stable.
REQ-020 In HOLD with out_ready=1 and in_valid=0, next state SHALL be IDLE.
REQ-021 In HOLD with out_ready=1 and in_valid=1, the output SHALL be consumed and a new frame started per REQ-016 on the same edge (no bubble).
REQ-022 A carry out of bit ACC_W-1 SHALL set out_ovf, which stays set until the next frame starts.
REQ-023 clear=1 SHALL have priority over every other event: next state IDLE, acc=0, cnt=0, out_ovf=0. A transfer coinciding with clear SHALL be discarded.
REQ-024 out_sum SHALL be driven from acc in all states.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, acc=0, cnt=0, out_sum=0, out_ovf=0 and out_valid=0, including mid-frame.
REQ-026 in_ready SHALL read 1 during and after reset.

Configuration
REQ-027 With SATURATE_EN defined, an overflowing add SHALL clamp acc at 2^ACC_W-1, and acc SHALL stay clamped for the rest of the frame.
REQ-028 Without SATURATE_EN, acc SHALL wrap modulo 2^ACC_W.
REQ-029 out_ovf behaviour SHALL be identical with and without SATURATE_EN.

Structure
REQ-030 The shared package SHALL hold the state encodings IDLE, ACC and HOLD and the default ACC_W and BEATS constants.
REQ-031 The beat counter (load, increment, terminal flag cnt==BEATS-1) SHALL be a sub-module named beat_counter.
REQ-032 Accumulator, overflow and FSM logic SHALL reside in product_accumulator.

Verification
REQ-033 Defaults; products 3,5,7,9 with idle gaps -> out_sum=24, out_ovf=0, out_valid 1 cycle after the 4th transfer, held stable while out_ready=0 for 3 cycles.
REQ-034 HOLD holding 24, out_ready=1, in_valid=1, in_p=10, then 1,1,1 -> no bubble, next out_sum=13.
REQ-035 ACC_W=10, BEATS=5, five products of 225 -> without SATURATE_EN out_sum=101, out_ovf=1; with SATURATE_EN out_sum=1023, out_ovf=1.
REQ-036 clear pulsed after 2 transfers (coincident with a third transfer) -> IDLE; then four products of 1 -> out_sum=4, out_ovf=0.
REQ-037 rst_n pulled low asynchronously mid-ACC -> out_valid=0 and out_sum=0 before the next clk edge; the next frame 2,2,2,2 -> out_sum=8.
REQ-038 End-to-end with the upstream multiplier: four operand pairs a=15,b=15 -> out_sum=900, out_ovf=0.
